// File: rtl/cpu_memory_responder.sv
// Responder for the CPU nibble memory bus: work RAM, display RAM with a scan-out port, and an I/O window.
// Define RAM_CLEAR_EN to zero both RAMs after every reset (busy stays high while clearing).
module cpu_memory_responder #(
    parameter int          RAM_WORDS  = 640,
    parameter logic [11:0] VRAM_BASE  = 12'hE00,
    parameter int          VRAM_WORDS = 128,
    parameter logic [11:0] IO_BASE    = 12'hF00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        memory_write_en,
    input  logic [11:0] memory_addr,
    input  logic [3:0]  memory_write_data,
    output logic [3:0]  memory_read_data,
    output logic        io_write_en,
    output logic [6:0]  io_addr,
    output logic [3:0]  io_write_data,
    input  logic [3:0]  io_read_data,
    input  logic [6:0]  video_addr,
    output logic [3:0]  video_data,
    output logic        busy
);
    localparam int          RAM_AW  = $clog2(RAM_WORDS);
    localparam int          VRAM_AW = $clog2(VRAM_WORDS);
    localparam logic [12:0] RAM_END = 13'(RAM_WORDS);
    localparam logic [12:0] VRAM_LO = {1'b0, VRAM_BASE};
    localparam logic [12:0] VRAM_HI = VRAM_LO + 13'(VRAM_WORDS);
    localparam logic [12:0] IO_LO   = {1'b0, IO_BASE};
    localparam logic [12:0] IO_HI   = IO_LO + 13'd128;

    logic [3:0] ram_mem  [RAM_WORDS];
    logic [3:0] vram_mem [VRAM_WORDS];

    logic               hit_ram;
    logic               hit_vram;
    logic               hit_io;
    logic [RAM_AW-1:0]  ram_idx;
    logic [VRAM_AW-1:0] vram_idx;
    logic [VRAM_AW-1:0] video_idx;
    logic               video_in_range;
    logic [6:0]         io_off;

    logic               clearing;
    logic               clr_ram_we;
    logic               clr_vram_we;
    logic [RAM_AW-1:0]  clr_ram_idx;
    logic [VRAM_AW-1:0] clr_vram_idx;

    logic               cpu_we;
    logic               ram_we;
    logic               vram_we;
    logic [RAM_AW-1:0]  ram_widx;
    logic [VRAM_AW-1:0] vram_widx;
    logic [3:0]         wr_nibble;

    logic [3:0] memory_read_data_q, memory_read_data_d;
    logic [3:0] video_data_q, video_data_d;
    logic       io_write_en_q, io_write_en_d;
    logic [6:0] io_waddr_q, io_waddr_d;
    logic [3:0] io_wdata_q, io_wdata_d;

    // Region decode in priority order RAM, VRAM, IO; offsets wrap in 12 bits then truncate.
    always_comb begin
        hit_ram        = {1'b0, memory_addr} < RAM_END;
        hit_vram       = !hit_ram && ({1'b0, memory_addr} >= VRAM_LO) && ({1'b0, memory_addr} < VRAM_HI);
        hit_io         = !hit_ram && !hit_vram && ({1'b0, memory_addr} >= IO_LO) && ({1'b0, memory_addr} < IO_HI);
        ram_idx        = RAM_AW'(memory_addr);
        vram_idx       = VRAM_AW'(memory_addr - VRAM_BASE);
        io_off         = 7'(memory_addr - IO_BASE);
        video_in_range = {25'd0, video_addr} < 32'(VRAM_WORDS);
        video_idx      = VRAM_AW'(video_addr);
    end

`ifdef RAM_CLEAR_EN
    localparam int   CLR_WORDS = (RAM_WORDS > VRAM_WORDS) ? RAM_WORDS : VRAM_WORDS;
    localparam int   CLR_W     = $clog2(CLR_WORDS);
    localparam logic ST_IDLE   = 1'b0;
    localparam logic ST_CLEAR  = 1'b1;

    logic             state_q, state_d;
    logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        if (state_q == ST_CLEAR) begin
            if (clr_cnt_q == CLR_W'(CLR_WORDS - 1)) begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end else begin
                clr_cnt_d = clr_cnt_q + 1'b1;
            end
        end
    end

    // Every reset, including one landing mid-clear, restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    assign clearing     = (state_q == ST_CLEAR);
    assign clr_ram_we   = clearing && ({1'b0, clr_cnt_q} < (CLR_W + 1)'(RAM_WORDS));
    assign clr_vram_we  = clearing && ({1'b0, clr_cnt_q} < (CLR_W + 1)'(VRAM_WORDS));
    assign clr_ram_idx  = RAM_AW'(clr_cnt_q);
    assign clr_vram_idx = VRAM_AW'(clr_cnt_q);
`else
    assign clearing     = 1'b0;
    assign clr_ram_we   = 1'b0;
    assign clr_vram_we  = 1'b0;
    assign clr_ram_idx  = '0;
    assign clr_vram_idx = '0;
`endif

    assign busy = clearing;

    always_comb begin
        cpu_we    = memory_write_en && reset_n && !clearing;
        ram_we    = (cpu_we && hit_ram) || clr_ram_we;
        vram_we   = (cpu_we && hit_vram) || clr_vram_we;
        ram_widx  = clearing ? clr_ram_idx : ram_idx;
        vram_widx = clearing ? clr_vram_idx : vram_idx;
        wr_nibble = clearing ? 4'h0 : memory_write_data;
    end

    // Arrays are read combinationally before the edge, so a same-edge write yields the old nibble.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_widx] <= wr_nibble;
        end
        if (vram_we) begin
            vram_mem[vram_widx] <= wr_nibble;
        end
    end

    always_comb begin
        memory_read_data_d = 4'h0;
        if (!clearing) begin
            if (hit_ram) begin
                memory_read_data_d = ram_mem[ram_idx];
            end else if (hit_vram) begin
                memory_read_data_d = vram_mem[vram_idx];
            end else if (hit_io) begin
                memory_read_data_d = io_read_data;
            end
        end
        video_data_d  = (!clearing && video_in_range) ? vram_mem[video_idx] : 4'h0;
        io_write_en_d = cpu_we && hit_io;
        io_waddr_d    = io_write_en_d ? io_off : io_waddr_q;
        io_wdata_d    = io_write_en_d ? memory_write_data : io_wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            memory_read_data_q <= 4'h0;
            video_data_q       <= 4'h0;
            io_write_en_q      <= 1'b0;
            io_waddr_q         <= 7'h00;
            io_wdata_q         <= 4'h0;
        end else begin
            memory_read_data_q <= memory_read_data_d;
            video_data_q       <= video_data_d;
            io_write_en_q      <= io_write_en_d;
            io_waddr_q         <= io_waddr_d;
            io_wdata_q         <= io_wdata_d;
        end
    end

    // While the strobe is up the peripheral sees the committed write, even if the CPU has moved on.
    assign memory_read_data = memory_read_data_q;
    assign video_data       = video_data_q;
    assign io_write_en      = io_write_en_q;
    assign io_addr          = io_write_en_q ? io_waddr_q : io_off;
    assign io_write_data    = io_write_en_q ? io_wdata_q : memory_write_data;

endmodule

// File: tb/tb_cpu_memory_responder.sv
// Scoreboard bench for cpu_memory_responder: a reference nibble map predicts every read at drive time.
// Build with RAM_CLEAR_EN defined to also exercise the post-reset clear sweep.
module tb_cpu_memory_responder;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        memory_write_en;
    logic [11:0] memory_addr;
    logic [3:0]  memory_write_data;
    logic [3:0]  memory_read_data;
    logic        io_write_en;
    logic [6:0]  io_addr;
    logic [3:0]  io_write_data;
    logic [3:0]  io_read_data;
    logic [6:0]  video_addr;
    logic [3:0]  video_data;
    logic        busy;

    int nvec = 0;
    int nmis = 0;

    logic [3:0] ref_mem [4096];
    logic [3:0] rd_q [$];
    logic [3:0] vid_q [$];

`ifdef RAM_CLEAR_EN
    localparam logic EXP_RESET_BUSY = 1'b1;
`else
    localparam logic EXP_RESET_BUSY = 1'b0;
`endif

    always #5 clk = ~clk;

    cpu_memory_responder dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .memory_write_en  (memory_write_en),
        .memory_addr      (memory_addr),
        .memory_write_data(memory_write_data),
        .memory_read_data (memory_read_data),
        .io_write_en      (io_write_en),
        .io_addr          (io_addr),
        .io_write_data    (io_write_data),
        .io_read_data     (io_read_data),
        .video_addr       (video_addr),
        .video_data       (video_data),
        .busy             (busy)
    );

    function automatic logic is_mem(input logic [11:0] a);
        return (a < 12'd640) || (a >= 12'hE00 && a < 12'hE80);
    endfunction

    function automatic logic [3:0] exp_read(input logic [11:0] a, input logic [3:0] io_val);
        if (is_mem(a)) return ref_mem[a];
        if (a >= 12'hF00 && a < 12'hF80) return io_val;
        return 4'h0;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 4096; i++) begin
            if (is_mem(12'(i))) ref_mem[i] = 4'h0;
        end
    endfunction

    // Predictions are taken before the model is updated, giving read-first behaviour on both ports.
    task automatic drive(input logic [11:0] a, input logic we, input logic [3:0] wd);
        memory_addr       = a;
        memory_write_en   = we;
        memory_write_data = wd;
        rd_q.push_back(exp_read(a, io_read_data));
        vid_q.push_back(ref_mem[12'hE00 + {5'd0, video_addr}]);
        if (we && is_mem(a)) ref_mem[a] = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic take(output logic [3:0] e_rd, output logic [3:0] e_vid);
        e_rd  = rd_q.pop_front();
        e_vid = vid_q.pop_front();
    endtask

    task automatic test_reset;
        int cycles;
        reset_n = 1'b0; memory_write_en = 1'b0; memory_addr = 12'h000;
        memory_write_data = 4'h0; video_addr = 7'h00; io_read_data = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        nvec++; if (memory_read_data !== 4'h0) begin nmis++; $display("[TB] FAIL reset_rd: got %h expected 0", memory_read_data); end
        nvec++; if (video_data !== 4'h0) begin nmis++; $display("[TB] FAIL reset_video: got %h expected 0", video_data); end
        nvec++; if (io_write_en !== 1'b0) begin nmis++; $display("[TB] FAIL reset_io_we: got %b expected 0", io_write_en); end
        nvec++; if (busy !== EXP_RESET_BUSY) begin nmis++; $display("[TB] FAIL reset_busy: got %b expected %b", busy, EXP_RESET_BUSY); end
        reset_n = 1'b1;
        cycles = 0;
        while (busy === 1'b1 && cycles < 2000) begin
            @(posedge clk); #1; cycles++;
        end
        nvec++; if (busy !== 1'b0) begin nmis++; $display("[TB] FAIL reset_busy_release: got %b expected 0 after %0d cycles", busy, cycles); end
`ifdef RAM_CLEAR_EN
        model_clear();
`endif
    endtask

    task automatic test_ram_rw;
        logic [3:0]  e, v;
        logic [11:0] addrs [5];
        addrs = '{12'h010, 12'h000, 12'h27F, 12'h155, 12'h3A0};
        drive(12'h010, 1'b1, 4'hA); take(e, v);
        drive(12'h010, 1'b0, 4'h0); take(e, v);
        nvec++; if (memory_read_data !== e || e !== 4'hA) begin nmis++; $display("[TB] FAIL ram_rd_010: got %h expected %h", memory_read_data, 4'hA); end
        for (int i = 1; i < 5; i++) begin
            drive(addrs[i], 1'b1, 4'(i * 3 + 1)); take(e, v);
        end
        for (int i = 1; i < 5; i++) begin
            drive(addrs[i], 1'b0, 4'h0); take(e, v);
            nvec++; if (memory_read_data !== e) begin nmis++; $display("[TB] FAIL ram_rd_%h: got %h expected %h", addrs[i], memory_read_data, e); end
        end
    endtask

    task automatic test_read_first;
        logic [3:0] e, v;
        drive(12'h020, 1'b1, 4'h3); take(e, v);
        drive(12'h020, 1'b1, 4'h5); take(e, v);
        nvec++; if (memory_read_data !== 4'h3) begin nmis++; $display("[TB] FAIL read_first_old: got %h expected 3", memory_read_data); end
        drive(12'h020, 1'b0, 4'h0); take(e, v);
        nvec++; if (memory_read_data !== e) begin nmis++; $display("[TB] FAIL read_first_new: got %h expected %h", memory_read_data, e); end
    endtask

    task automatic test_vram;
        logic [3:0] e, v;
        video_addr = 7'h00;
        drive(12'hE05, 1'b1, 4'h7); take(e, v);
        video_addr = 7'h05;
        drive(12'hE05, 1'b0, 4'h0); take(e, v);
        nvec++; if (memory_read_data !== e) begin nmis++; $display("[TB] FAIL vram_cpu_rd: got %h expected %h", memory_read_data, e); end
        nvec++; if (video_data !== v || v !== 4'h7) begin nmis++; $display("[TB] FAIL video_rd: got %h expected 7", video_data); end
        drive(12'hE05, 1'b1, 4'h2); take(e, v);
        nvec++; if (video_data !== v) begin nmis++; $display("[TB] FAIL video_read_first: got %h expected %h", video_data, v); end
        drive(12'hE7F, 1'b1, 4'hC); take(e, v);
        nvec++; if (video_data !== v) begin nmis++; $display("[TB] FAIL video_new: got %h expected %h", video_data, v); end
        video_addr = 7'h7F;
        drive(12'hE7F, 1'b0, 4'h0); take(e, v);
        nvec++; if (memory_read_data !== e) begin nmis++; $display("[TB] FAIL vram_top_cpu: got %h expected %h", memory_read_data, e); end
        nvec++; if (video_data !== v) begin nmis++; $display("[TB] FAIL vram_top_video: got %h expected %h", video_data, v); end
    endtask

    task automatic test_io;
        logic [3:0] e, v;
        io_read_data = 4'h0;
        drive(12'hF12, 1'b1, 4'h9); take(e, v);
        nvec++; if (io_write_en !== 1'b1) begin nmis++; $display("[TB] FAIL io_strobe: got %b expected 1", io_write_en); end
        nvec++; if (io_addr !== 7'h12) begin nmis++; $display("[TB] FAIL io_addr: got %h expected 12", io_addr); end
        nvec++; if (io_write_data !== 4'h9) begin nmis++; $display("[TB] FAIL io_wdata: got %h expected 9", io_write_data); end
        io_read_data = 4'hC;
        drive(12'hF12, 1'b0, 4'h0); take(e, v);
        nvec++; if (io_write_en !== 1'b0) begin nmis++; $display("[TB] FAIL io_strobe_single: got %b expected 0", io_write_en); end
        nvec++; if (memory_read_data !== e) begin nmis++; $display("[TB] FAIL io_rd: got %h expected %h", memory_read_data, e); end
        drive(12'hF00, 1'b1, 4'h1); take(e, v);
        nvec++; if (io_write_en !== 1'b1 || io_addr !== 7'h00 || io_write_data !== 4'h1) begin
            nmis++; $display("[TB] FAIL io_b2b_first: got we=%b addr=%h data=%h expected 1/00/1", io_write_en, io_addr, io_write_data);
        end
        drive(12'hF7F, 1'b1, 4'h2); take(e, v);
        nvec++; if (io_write_en !== 1'b1 || io_addr !== 7'h7F || io_write_data !== 4'h2) begin
            nmis++; $display("[TB] FAIL io_b2b_second: got we=%b addr=%h data=%h expected 1/7f/2", io_write_en, io_addr, io_write_data);
        end
        drive(12'h000, 1'b0, 4'h0); take(e, v);
        nvec++; if (io_write_en !== 1'b0) begin nmis++; $display("[TB] FAIL io_b2b_end: got %b expected 0", io_write_en); end
        io_read_data = 4'h0;
    endtask

    task automatic test_unmapped;
        logic [3:0]  e, v;
        logic [11:0] addrs [4];
        addrs = '{12'h900, 12'h280, 12'hE80, 12'hF80};
        for (int i = 0; i < 4; i++) begin
            drive(addrs[i], 1'b1, 4'hF); take(e, v);
            nvec++; if (io_write_en !== 1'b0) begin nmis++; $display("[TB] FAIL unmapped_strobe_%h: got %b expected 0", addrs[i], io_write_en); end
            drive(addrs[i], 1'b0, 4'h0); take(e, v);
            nvec++; if (memory_read_data !== 4'h0) begin nmis++; $display("[TB] FAIL unmapped_rd_%h: got %h expected 0", addrs[i], memory_read_data); end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0]  e, v;
        logic [11:0] pool [8];
        logic [11:0] a;
        logic        we;
        pool = '{12'h001, 12'h07F, 12'h200, 12'h27E, 12'h3FF, 12'hE00, 12'hE10, 12'hE7E};
        for (int i = 0; i < 8; i++) begin
            drive(pool[i], 1'b1, 4'($urandom)); take(e, v);
        end
        for (int i = 0; i < 40; i++) begin
            a  = pool[$urandom_range(0, 7)];
            we = 1'($urandom_range(0, 1));
            drive(a, we, 4'($urandom)); take(e, v);
            nvec++; if (memory_read_data !== e) begin nmis++; $display("[TB] FAIL b2b_%0d_%h: got %h expected %h", i, a, memory_read_data, e); end
        end
    endtask

`ifdef RAM_CLEAR_EN
    task automatic test_ram_clear;
        logic [3:0] e, v;
        int         cycles;
        video_addr = 7'h05;
        drive(12'h000, 1'b1, 4'hB); take(e, v);
        drive(12'h000, 1'b0, 4'h0); take(e, v);
        nvec++; if (memory_read_data !== 4'hB) begin nmis++; $display("[TB] FAIL clear_preload: got %h expected b", memory_read_data); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            memory_addr     = (i == 60) ? 12'hF05 : 12'h000;
            memory_write_en = (i == 60);
            @(posedge clk); #1;
            if (i == 50) begin
                nvec++; if (memory_read_data !== 4'h0) begin nmis++; $display("[TB] FAIL clear_rd_zero: got %h expected 0", memory_read_data); end
                nvec++; if (video_data !== 4'h0) begin nmis++; $display("[TB] FAIL clear_video_zero: got %h expected 0", video_data); end
            end
            if (i == 60) begin
                nvec++; if (io_write_en !== 1'b0) begin nmis++; $display("[TB] FAIL clear_io_blocked: got %b expected 0", io_write_en); end
            end
        end
        memory_write_en = 1'b0;
        memory_addr     = 12'h000;
        nvec++; if (busy !== 1'b1) begin nmis++; $display("[TB] FAIL clear_busy_mid: got %b expected 1", busy); end
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        cycles = 0;
        while (busy === 1'b1 && cycles < 2000) begin
            @(posedge clk); #1; cycles++;
        end
        nvec++; if (cycles != 640) begin nmis++; $display("[TB] FAIL clear_length: got %0d cycles expected 640", cycles); end
        model_clear();
        drive(12'h000, 1'b0, 4'h0); take(e, v);
        nvec++; if (memory_read_data !== e || e !== 4'h0) begin nmis++; $display("[TB] FAIL clear_result: got %h expected 0", memory_read_data); end
        nvec++; if (video_data !== 4'h0) begin nmis++; $display("[TB] FAIL clear_video_result: got %h expected 0", video_data); end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_ram_rw();
        test_read_first();
        test_vram();
        test_io();
        test_unmapped();
        test_back_to_back();
`ifdef RAM_CLEAR_EN
        test_ram_clear();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
